// File: rtl/crank_wheel_gen_if.sv
// crank_wheel_gen_if: register-bus strobes and address for crank_wheel_gen
// Signals: ssram_we (write strobe), ssram_re (read enable), ssram_addr (8-bit address).
// The 16-bit data bus is tri-state and travels as a plain inout port beside this interface.
interface crank_wheel_gen_if;
  logic ssram_we;
  logic ssram_re;
  logic [7:0] ssram_addr;
  modport master (output ssram_we, ssram_re, ssram_addr);
  modport slave (input ssram_we, ssram_re, ssram_addr);
endinterface

// File: rtl/crank_wheel_gen.sv
// crank_wheel_gen: register-programmed N-M crank-wheel VR signal emulator
// Ports: clk, rst (sync, active-high); ssram (we/re/addr) with ssram_data tri-state bus,
//   registers at BASE..BASE+5; vr_out tooth signal, gap_sync revolution pulse, cam_out cam phase.
// Option: define CRANK_WHEEL_GEN_CAM_EN to enable cam_out and the STAT parity bit.
module crank_wheel_gen #(
  parameter logic [7:0] BASE = 8'h20,
  parameter int PW = 24
) (
  input  logic clk,
  input  logic rst,
  crank_wheel_gen_if.slave ssram,
  inout  wire [15:0] ssram_data,
  output logic vr_out,
  output logic gap_sync,
  output logic cam_out
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [1:0] cr_q, miss_q, m_s_q, m_s_d;
  logic [15:0] perl_q, rd_data;
  logic [7:0] perh_q, teeth_q, n_s_q, n_s_d, idx_q, idx_d, n_eff, m_eff, off;
  logic [PW-1:0] per_s_q, per_s_d, cnt_q, cnt_d, p_eff, per_w;
  logic start, run, slot_end, rev_end, wave, wr, hit, par;
  assign off = ssram.ssram_addr - BASE;
  assign wr = ssram.ssram_we && off < 8'd6;
  assign hit = ssram.ssram_re && off < 8'd6;
  assign per_w = PW'({perh_q, perl_q});
  assign p_eff = per_s_q < PW'(2) ? PW'(2) : per_s_q;
  assign n_eff = n_s_q < 8'd3 ? 8'd3 : n_s_q;
  assign m_eff = {6'd0, m_s_q} > n_eff - 8'd2 ? n_eff - 8'd2 : {6'd0, m_s_q};
  assign slot_end = cnt_q == p_eff - PW'(1);
  assign rev_end = slot_end && idx_q == n_eff - 8'd1;
  assign wave = (idx_q < n_eff - m_eff) && (cnt_q < (p_eff >> 1));
  // start is the first cycle after EN rises; run is steady operation with EN still set
  always_comb begin
    state_d = cr_q[0] ? RUN : IDLE;
    start = cr_q[0] && state_q == IDLE;
    run = cr_q[0] && state_q == RUN;
    cnt_d = (run && !slot_end) ? cnt_q + PW'(1) : '0;
    idx_d = (!run || rev_end) ? '0 : idx_q + {7'd0, slot_end};
    per_s_d = (start || (run && slot_end)) ? per_w : per_s_q;
    n_s_d = (start || (run && rev_end)) ? teeth_q : n_s_q;
    m_s_d = (start || (run && rev_end)) ? miss_q : m_s_q;
  end
  always_comb begin
    case (off)
      8'd0: rd_data = {14'd0, cr_q};
      8'd1: rd_data = perl_q;
      8'd2: rd_data = {8'd0, perh_q};
      8'd3: rd_data = {8'd0, teeth_q};
      8'd4: rd_data = {14'd0, miss_q};
      8'd5: rd_data = {7'd0, par, idx_q};
      default: rd_data = '0;
    endcase
  end
  assign ssram_data = hit ? rd_data : 'z;
  always_ff @(posedge clk) begin
    if (rst) begin
      cr_q <= '0;
      perl_q <= '0;
      perh_q <= '0;
      teeth_q <= '0;
      miss_q <= '0;
      state_q <= IDLE;
      per_s_q <= '0;
      n_s_q <= '0;
      m_s_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      vr_out <= 1'b0;
      gap_sync <= 1'b0;
    end else begin
      if (wr && off == 8'd0) cr_q <= ssram_data[1:0];
      if (wr && off == 8'd1) perl_q <= ssram_data;
      if (wr && off == 8'd2) perh_q <= ssram_data[7:0];
      if (wr && off == 8'd3) teeth_q <= ssram_data[7:0];
      if (wr && off == 8'd4) miss_q <= ssram_data[1:0];
      state_q <= state_d;
      per_s_q <= per_s_d;
      n_s_q <= n_s_d;
      m_s_q <= m_s_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      vr_out <= (run && wave) ^ cr_q[1];
      gap_sync <= run && cnt_q == '0 && idx_q == '0;
    end
  end
`ifdef CRANK_WHEEL_GEN_CAM_EN
  logic par_q;
  assign par = par_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
      cam_out <= 1'b0;
    end else begin
      par_q <= run && (par_q ^ rev_end);
      cam_out <= run && par_q && idx_q == '0;
    end
  end
`else
  assign par = 1'b0;
  assign cam_out = 1'b0;
`endif
endmodule

// File: tb/tb_crank_wheel_gen.sv
// tb_crank_wheel_gen: randomized self-checking bench against a slot-level waveform model
module tb_crank_wheel_gen;
  localparam logic [7:0] BASE = 8'h20;
`ifdef CRANK_WHEEL_GEN_CAM_EN
  localparam bit CAM = 1'b1;
`else
  localparam bit CAM = 1'b0;
`endif
  typedef struct {bit vr; bit gap; bit cam; int idx; bit par;} ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic host_oe = 1'b0;
  logic [15:0] host_d = '0;
  wire [15:0] ssram_data;
  logic vr_out, gap_sync, cam_out;
  int errs = 0;
  int checks = 0;
  int r_per, r_n, r_m, mi, mpar, mn, mm;
  bit r_pol;
  ent_t q[$];
  crank_wheel_gen_if bus ();
  assign ssram_data = host_oe ? host_d : 16'hzzzz;
  pullup (ssram_data);
  crank_wheel_gen #(.BASE(BASE), .PW(24)) dut (
    .clk(clk), .rst(rst), .ssram(bus), .ssram_data(ssram_data),
    .vr_out(vr_out), .gap_sync(gap_sync), .cam_out(cam_out)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic put(input logic [7:0] a, input logic [15:0] d);
    bus.ssram_we = 1'b1;
    bus.ssram_addr = a;
    host_oe = 1'b1;
    host_d = d;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    bus.ssram_we = 1'b0;
    host_oe = 1'b0;
  endtask
  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    put(a, d);
    tick();
  endtask
  task automatic rd(input logic [7:0] a, output logic [15:0] d);
    bus.ssram_re = 1'b1;
    bus.ssram_addr = a;
    #1;
    d = ssram_data;
    bus.ssram_re = 1'b0;
    #1;
  endtask
  // Append one whole tooth slot of expected samples; N and M are taken at revolution start,
  // the period at every slot start, from the most recently written register values.
  function automatic void gen();
    int p;
    ent_t e;
    p = r_per < 2 ? 2 : r_per;
    if (mi == 0) begin
      mn = r_n < 3 ? 3 : r_n;
      mm = r_m > mn - 2 ? mn - 2 : r_m;
    end
    for (int k = 0; k < p; k++) begin
      e.vr = (mi < mn - mm) && (k < p / 2);
      e.gap = mi == 0 && k == 0;
      e.cam = mi == 0 && mpar == 1;
      e.idx = mi;
      e.par = mpar[0];
      q.push_back(e);
    end
    mi++;
    if (mi == mn) begin
      mi = 0;
      mpar ^= 1;
    end
  endfunction
  task automatic run_model(input int n);
    ent_t e;
    logic [15:0] s;
    repeat (n) begin
      tick();
      if (q.size() == 0) gen();
      e = q.pop_front();
      chk("vr_out", vr_out, e.vr ^ r_pol);
      chk("gap_sync", gap_sync, e.gap);
      chk("cam_out", cam_out, CAM & e.cam);
      if (q.size() == 0) gen();
      rd(BASE + 8'd5, s);
      chk("stat", s, (int'(CAM & q[0].par) << 8) | q[0].idx);
    end
  endtask
  task automatic start(input int per, input int n, input int m, input bit pol);
    wr(BASE, 16'(pol) << 1);
    wr(BASE + 8'd1, 16'(per));
    wr(BASE + 8'd2, 16'd0);
    wr(BASE + 8'd3, 16'(n));
    wr(BASE + 8'd4, 16'(m));
    r_per = per;
    r_n = n;
    r_m = m;
    r_pol = pol;
    chk("vr_idle", vr_out, pol);
    chk("gap_idle", gap_sync, 0);
    wr(BASE, (16'(pol) << 1) | 16'd1);
    tick();
    chk("vr_load", vr_out, pol);
    q.delete();
    mi = 0;
    mpar = 0;
  endtask
  task automatic stop();
    logic [15:0] s;
    wr(BASE, 16'(r_pol) << 1);
    tick();
    chk("vr_stop", vr_out, r_pol);
    chk("gap_stop", gap_sync, 0);
    chk("cam_stop", cam_out, 0);
    rd(BASE + 8'd5, s);
    chk("stat_stop", s, 0);
  endtask
  initial begin
    logic [15:0] d, v;
    int cfg[4][4] = '{'{10, 6, 1, 0}, '{1, 2, 3, 0}, '{4, 4, 0, 0}, '{10, 6, 1, 1}};
    int p, n, m;
    bit pol;
    bus.ssram_we = 1'b0;
    bus.ssram_re = 1'b0;
    bus.ssram_addr = '0;
    repeat (3) tick();
    chk("rst_vr", vr_out, 0);
    chk("rst_gap", gap_sync, 0);
    chk("rst_cam", cam_out, 0);
    for (int a = 0; a < 6; a++) begin
      rd(8'(BASE + a), d);
      chk("rst_reg", d, 0);
    end
    rd(BASE + 8'd6, d);
    chk("hiz_above", d, 16'hffff);
    rd(BASE - 8'd1, d);
    chk("hiz_below", d, 16'hffff);
    rst = 1'b0;
    tick();
    for (int a = 0; a < 5; a++) begin
      v = 16'($urandom);
      if (a == 0) v[0] = 1'b0;
      wr(8'(BASE + a), v);
      rd(8'(BASE + a), d);
      chk("reg_mask", d, a == 0 ? v & 16'h3 : a == 1 ? v : a == 4 ? v & 16'h3 : v & 16'hff);
    end
    wr(BASE + 8'd5, 16'hffff);
    rd(BASE + 8'd5, d);
    chk("stat_ro", d, 0);
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        p = cfg[i][0];
        n = cfg[i][1];
        m = cfg[i][2];
        pol = cfg[i][3][0];
      end else begin
        p = $urandom_range(1, 12);
        n = $urandom_range(0, 9);
        m = $urandom_range(0, 3);
        pol = 1'($urandom_range(0, 1));
      end
      start(p, n, m, pol);
      run_model(2 * (p < 2 ? 2 : p) * (n < 3 ? 3 : n) + 5);
      stop();
    end
    start(10, 6, 1, 0);
    run_model(13);
    put(BASE + 8'd1, 16'd20);
    r_per = 20;
    run_model(41);
    put(BASE + 8'd3, 16'd4);
    r_n = 4;
    run_model(200);
    put(BASE, 16'd3);
    run_model(1);
    r_pol = 1'b1;
    run_model(30);
    stop();
    start(6, 5, 1, 1);
    run_model(17);
    rst = 1'b1;
    put(BASE, 16'd3);
    tick();
    rst = 1'b0;
    chk("rst_run_vr", vr_out, 0);
    chk("rst_run_gap", gap_sync, 0);
    chk("rst_run_cam", cam_out, 0);
    rd(BASE, d);
    chk("rst_run_cr", d, 0);
    rd(BASE + 8'd1, d);
    chk("rst_run_perl", d, 0);
    rd(BASE + 8'd5, d);
    chk("rst_run_stat", d, 0);
    tick();
    chk("rst_after_vr", vr_out, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
